// File: rtl/mean_decim_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mean_decim_fifo
//  Purpose  : Output stage behind the moving-average (MEAN) filter. Keeps every
//             DECIM-th strobed sample and buffers the kept samples in a
//             first-word-fall-through FIFO that is read through a valid/ready
//             handshake. A kept sample that finds the FIFO full (and no pop on
//             the same edge) is dropped and raises a sticky overflow flag.
//  Ports    : clk           - single clock, all state on the rising edge
//             rst           - asynchronous reset, active low (0 = reset)
//             data_i_en     - input sample strobe
//             data_i        - input sample, signed two's complement, SW bits
//             data_o_ready  - consumer accepts data_o this cycle
//             clr_ovf       - synchronous clear of the overflow flag
//             data_o_valid  - FIFO non-empty, data_o holds the head sample
//             data_o        - head sample, 0 while data_o_valid is 0
//             fifo_level    - number of stored entries, 0..FIFO_DEPTH
//             overflow      - sticky: a kept sample was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module mean_decim_fifo #(
   parameter int width_H    = 5,
   parameter int width_W    = 20,
   parameter int DECIM      = 4,
   parameter int log_DEPTH  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         data_i_en,
   input  logic [width_H+width_W-1:0]   data_i,
   input  logic                         data_o_ready,
   input  logic                         clr_ovf,
   output logic                         data_o_valid,
   output logic [width_H+width_W-1:0]   data_o,
   output logic [log_DEPTH:0]           fifo_level,
   output logic                         overflow
);

   localparam int c_sw = width_H + width_W;
   localparam int c_pw = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int c_lw = log_DEPTH + 1;

   localparam logic [c_pw-1:0] c_ph_last    = c_pw'(DECIM - 1);
   localparam logic [c_pw-1:0] c_ph_zero    = '0;
   localparam logic [c_lw-1:0] c_full_level = c_lw'(FIFO_DEPTH);
   localparam logic [c_lw-1:0] c_zero_level = '0;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [c_pw-1:0]      r_phase;
   logic [log_DEPTH-1:0] r_wr_ptr;
   logic [log_DEPTH-1:0] r_rd_ptr;
   logic [c_lw-1:0]      r_level;
   logic                 r_overflow;
   logic [c_sw-1:0]      r_mem [0:FIFO_DEPTH-1];

   // ------------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------------
   logic w_keep;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   always_comb begin
      w_keep  = data_i_en && (r_phase == c_ph_zero);
      w_empty = (r_level == c_zero_level);
      w_full  = (r_level == c_full_level);
      w_pop   = !w_empty && data_o_ready;
      // A full FIFO still accepts a kept sample when the head leaves on the
      // same edge; the slot freed by the pop is the one being written.
      w_push  = w_keep && (!w_full || w_pop);
      w_drop  = w_keep && w_full && !w_pop;
   end

   // ------------------------------------------------------------------------
   // Decimation phase: advances only on strobed samples.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase <= c_ph_zero;
      end else if (data_i_en) begin
         if (r_phase == c_ph_last) begin
            r_phase <= c_ph_zero;
         end else begin
            r_phase <= r_phase + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Pointers and level. Pointers wrap naturally because the depth is a power
   // of two; full/empty come from the level, not from pointer comparison.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= c_zero_level;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Storage: not reset, contents are meaningless once the level is cleared.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky overflow: a drop on the same edge wins over a clear.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded from registered state only. The async reset clears the
   // level, which forces valid and data low without waiting for an edge.
   // ------------------------------------------------------------------------
   assign data_o_valid = !w_empty;
   assign data_o       = w_empty ? '0 : r_mem[r_rd_ptr];
   assign fifo_level   = r_level;
   assign overflow     = r_overflow;

endmodule
`default_nettype wire
